// File: rtl/bundle_pkg.sv
// Shared types and defaults for the bundling-datapath scheduler.
package bundle_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int LEN_WIDTH_DEF = 16;
  localparam int IDX_WIDTH_DEF = $clog2(NUM_REQ_DEF);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [IDX_WIDTH_DEF-1:0] idx;
    logic [LEN_WIDTH_DEF-1:0] len;
  } job_t;

endpackage

// File: rtl/bundle_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [IDX_WIDTH-1:0] i_ptr,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [IDX_WIDTH-1:0] o_idx,
  output logic                 o_any
);

  // Bit k of the rotated vector is requester (i_ptr + k) mod NUM_REQ.
  logic [2*NUM_REQ-1:0] w_rot;
  logic [IDX_WIDTH:0]   w_sum;

  assign w_rot = {i_req, i_req} >> i_ptr;

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_any && w_rot[k]) begin
        o_any = 1'b1;
        w_sum = {1'b0, i_ptr} + (IDX_WIDTH+1)'(k);
        if (w_sum >= (IDX_WIDTH+1)'(NUM_REQ)) begin
          w_sum = w_sum - (IDX_WIDTH+1)'(NUM_REQ);
        end
        o_idx = w_sum[IDX_WIDTH-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign o_grant[gi] = o_any && (o_idx == IDX_WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/bundle_scheduler.sv
// Shares one accumulator bank between NUM_REQ requesters: arbitrate, clear,
// stream the winner's vectors, then report count and overflow.
module bundle_scheduler
  import bundle_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*LEN_WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]           req_ack,
  input  logic [NUM_REQ-1:0]           vec_valid,
  output logic [NUM_REQ-1:0]           vec_ready,
  output logic                         grant_valid,
  output logic [IDX_WIDTH-1:0]         grant_idx,
  output logic                         acc_clear,
  output logic                         acc_valid,
  input  logic                         acc_overflow,
  output logic                         done,
  output logic [IDX_WIDTH-1:0]         done_idx,
  output logic [LEN_WIDTH-1:0]         done_count,
  output logic                         done_overflow
);

  state_t               r_state, w_state_next;
  logic [IDX_WIDTH-1:0] r_ptr, r_idx, r_done_idx;
  logic [LEN_WIDTH-1:0] r_len, r_cnt, r_done_count;
  logic                 r_ovf_seen, r_done_overflow;

  logic [NUM_REQ-1:0]   w_arb_grant, w_sel;
  logic [IDX_WIDTH-1:0] w_arb_idx;
  logic                 w_arb_any, w_run, w_last, w_in_done;
  logic [LEN_WIDTH-1:0] w_len_arr [NUM_REQ];

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_arb (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_arb_grant),
    .o_idx  (w_arb_idx),
    .o_any  (w_arb_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_len_arr[gi] = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
      assign w_sel[gi]     = (r_idx == IDX_WIDTH'(gi));
    end
  endgenerate

  // Strobes are suppressed while reset is held so an aborted job emits nothing.
  assign w_run       = !reset;
  assign w_in_done   = (r_state == ST_DONE);
  assign req_ack     = (w_run && r_state == ST_IDLE) ? w_arb_grant : '0;
  assign vec_ready   = (w_run && r_state == ST_ACCUM) ? w_sel : '0;
  assign acc_valid   = |(vec_valid & vec_ready);
  assign acc_clear   = w_run && (r_state == ST_CLEAR);
  assign grant_valid = (r_state != ST_IDLE);
  assign grant_idx   = r_idx;
  assign w_last      = (r_cnt == r_len - LEN_WIDTH'(1));

  assign done          = w_run && w_in_done;
  assign done_idx      = w_in_done ? r_idx : r_done_idx;
  assign done_count    = w_in_done ? r_cnt : r_done_count;
  assign done_overflow = w_in_done ? (r_ovf_seen | acc_overflow) : r_done_overflow;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_arb_any) w_state_next = ST_CLEAR;
      ST_CLEAR: w_state_next = (r_len == '0) ? ST_DONE : ST_ACCUM;
      ST_ACCUM: if (acc_valid && w_last) w_state_next = ST_FLUSH;
      ST_FLUSH: w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_ptr           <= '0;
      r_idx           <= '0;
      r_len           <= '0;
      r_cnt           <= '0;
      r_ovf_seen      <= 1'b0;
      r_done_idx      <= '0;
      r_done_count    <= '0;
      r_done_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_any) begin
            r_idx <= w_arb_idx;
            r_len <= w_len_arr[w_arb_idx];
            r_ptr <= (w_arb_idx == IDX_WIDTH'(NUM_REQ-1)) ? '0 : w_arb_idx + 1'b1;
          end
        end
        ST_CLEAR: begin
          r_cnt      <= '0;
          r_ovf_seen <= 1'b0;
        end
        ST_ACCUM: begin
          if (acc_valid) r_cnt <= r_cnt + 1'b1;
          if (acc_overflow) r_ovf_seen <= 1'b1;
        end
        ST_FLUSH: begin
          if (acc_overflow) r_ovf_seen <= 1'b1;
        end
        ST_DONE: begin
          r_done_idx      <= r_idx;
          r_done_count    <= r_cnt;
          r_done_overflow <= r_ovf_seen | acc_overflow;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bundle_scheduler.sv
// Directed checks of bundle_scheduler: timing, round-robin order, len=0,
// vec_valid gaps, overflow capture and mid-job reset.
module tb_bundle_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_len;
  logic [3:0]  req_ack;
  logic [3:0]  vec_valid;
  logic [3:0]  vec_ready;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic        acc_clear;
  logic        acc_valid;
  logic        acc_overflow;
  logic        done;
  logic [1:0]  done_idx;
  logic [15:0] done_count;
  logic        done_overflow;

  int checks   = 0;
  int failures = 0;

  bundle_scheduler #(.NUM_REQ(4), .LEN_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_len      (req_len),
    .req_ack      (req_ack),
    .vec_valid    (vec_valid),
    .vec_ready    (vec_ready),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .acc_clear    (acc_clear),
    .acc_valid    (acc_valid),
    .acc_overflow (acc_overflow),
    .done         (done),
    .done_idx     (done_idx),
    .done_count   (done_count),
    .done_overflow(done_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ack"},   32'(req_ack), 0);
    chk({tag, "_rdy"},   32'(vec_ready), 0);
    chk({tag, "_gv"},    32'(grant_valid), 0);
    chk({tag, "_gidx"},  32'(grant_idx), 0);
    chk({tag, "_clr"},   32'(acc_clear), 0);
    chk({tag, "_accv"},  32'(acc_valid), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_didx"},  32'(done_idx), 0);
    chk({tag, "_dcnt"},  32'(done_count), 0);
    chk({tag, "_dovf"},  32'(done_overflow), 0);
  endtask

  // Runs the four cycles after a len=1 ack; nreq is applied from CLEAR on.
  task automatic job1(input int idx, input logic [3:0] nreq);
    @(negedge clk); req_valid = nreq; #1;
    chk("j1_clear", 32'(acc_clear), 1);
    @(negedge clk); #1;
    chk("j1_ready", 32'(vec_ready), 32'(1 << idx));
    chk("j1_accv",  32'(acc_valid), 1);
    chk("j1_gidx",  32'(grant_idx), 32'(idx));
    @(negedge clk); #1;
    chk("j1_flush_rdy", 32'(vec_ready), 0);
    @(negedge clk); #1;
    chk("j1_done", 32'(done), 1);
    chk("j1_didx", 32'(done_idx), 32'(idx));
    chk("j1_dcnt", 32'(done_count), 1);
    $display("job len=1 idx=%0d done_count=%0d", idx, done_count);
  endtask

  int pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    reset = 1'b1; req_valid = '0; req_len = '0; vec_valid = '0; acc_overflow = 1'b0;
    repeat (3) @(negedge clk);
    #1; all_zero("rst");

    // T1: requester 0, len=3, back-to-back vectors
    @(negedge clk); reset = 1'b0; req_valid = 4'b0001; req_len[15:0] = 16'd3; vec_valid = 4'b0001; #1;
    chk("t1_ack", 32'(req_ack), 32'b0001);
    @(negedge clk); req_valid = '0; #1;
    chk("t1_clear", 32'(acc_clear), 1);
    chk("t1_gv", 32'(grant_valid), 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("t1_accv", 32'(acc_valid), 1);
      chk("t1_rdy", 32'(vec_ready), 32'b0001);
    end
    @(negedge clk); #1;
    chk("t1_flush_rdy", 32'(vec_ready), 0);
    chk("t1_flush_accv", 32'(acc_valid), 0);
    @(negedge clk); #1;
    chk("t1_done", 32'(done), 1);
    chk("t1_didx", 32'(done_idx), 0);
    chk("t1_dcnt", 32'(done_count), 3);
    chk("t1_dovf", 32'(done_overflow), 0);
    $display("T1 job idx=0 len=3 done_count=%0d", done_count);
    @(negedge clk); vec_valid = '0; #1;
    chk("t1_idle_done", 32'(done), 0);
    chk("t1_idle_gv", 32'(grant_valid), 0);
    chk("t1_hold_cnt", 32'(done_count), 3);

    // T2: round-robin from rr_ptr=0 (fresh reset)
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; req_valid = 4'b1011; vec_valid = 4'b1111;
    req_len[15:0] = 16'd1; req_len[31:16] = 16'd1; req_len[63:48] = 16'd1; #1;
    chk("t2_ack0", 32'(req_ack), 32'b0001);
    job1(0, 4'b1010);
    @(negedge clk); #1; chk("t2_ack1", 32'(req_ack), 32'b0010);
    job1(1, 4'b1000);
    @(negedge clk); #1; chk("t2_ack3", 32'(req_ack), 32'b1000);
    job1(3, 4'b0000);
    @(negedge clk); req_valid = 4'b0011; #1;
    chk("t2_rereq", 32'(req_ack), 32'b0001);
    job1(0, 4'b0000);

    // T3: len=0 from requester 2
    @(negedge clk); req_valid = 4'b0100; req_len[47:32] = 16'd0; #1;
    chk("t3_ack", 32'(req_ack), 32'b0100);
    @(negedge clk); req_valid = '0; #1;
    chk("t3_clear", 32'(acc_clear), 1);
    chk("t3_clr_accv", 32'(acc_valid), 0);
    @(negedge clk); #1;
    chk("t3_done", 32'(done), 1);
    chk("t3_accv", 32'(acc_valid), 0);
    chk("t3_rdy", 32'(vec_ready), 0);
    chk("t3_didx", 32'(done_idx), 2);
    chk("t3_dcnt", 32'(done_count), 0);
    chk("t3_dovf", 32'(done_overflow), 0);
    $display("T3 job idx=2 len=0 done_count=%0d", done_count);

    // T4: requester 1, len=4, gappy vec_valid
    @(negedge clk); req_valid = 4'b0010; req_len[31:16] = 16'd4; vec_valid = 4'b1101; #1;
    chk("t4_ack", 32'(req_ack), 32'b0010);
    @(negedge clk); req_valid = '0; #1;
    chk("t4_clear", 32'(acc_clear), 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); vec_valid = (pat[i] != 0) ? 4'b1111 : 4'b1101; #1;
      chk("t4_accv", 32'(acc_valid), 32'(pat[i]));
      chk("t4_rdy", 32'(vec_ready), 32'b0010);
    end
    @(negedge clk); vec_valid = 4'b1111; #1;
    chk("t4_flush_rdy", 32'(vec_ready), 0);
    @(negedge clk); #1;
    chk("t4_done", 32'(done), 1);
    chk("t4_didx", 32'(done_idx), 1);
    chk("t4_dcnt", 32'(done_count), 4);
    $display("T4 job idx=1 len=4 done_count=%0d", done_count);

    // T5: overflow seen after the 2nd of 3 adds, then a clean job
    @(negedge clk); req_valid = 4'b0100; req_len[47:32] = 16'd3; #1;
    chk("t5_ack", 32'(req_ack), 32'b0100);
    @(negedge clk); req_valid = '0; #1;
    chk("t5_clear", 32'(acc_clear), 1);
    @(negedge clk); #1; chk("t5_a1", 32'(acc_valid), 1);
    @(negedge clk); #1; chk("t5_a2", 32'(acc_valid), 1);
    @(negedge clk); acc_overflow = 1'b1; #1; chk("t5_a3", 32'(acc_valid), 1);
    @(negedge clk); acc_overflow = 1'b0; #1; chk("t5_flush_rdy", 32'(vec_ready), 0);
    @(negedge clk); #1;
    chk("t5_done", 32'(done), 1);
    chk("t5_dovf", 32'(done_overflow), 1);
    chk("t5_dcnt", 32'(done_count), 3);
    $display("T5 job idx=2 len=3 done_overflow=%0d", done_overflow);
    @(negedge clk); req_valid = 4'b1000; req_len[63:48] = 16'd1; #1;
    chk("t5_ack3", 32'(req_ack), 32'b1000);
    chk("t5_hold_ovf", 32'(done_overflow), 1);
    job1(3, 4'b0000);
    chk("t5_clean_ovf", 32'(done_overflow), 0);

    // T6: reset after 2 of 5 adds
    @(negedge clk); req_valid = 4'b0001; req_len[15:0] = 16'd5; #1;
    chk("t6_ack", 32'(req_ack), 32'b0001);
    @(negedge clk); req_valid = '0; #1;
    chk("t6_clear", 32'(acc_clear), 1);
    @(negedge clk); #1; chk("t6_a1", 32'(acc_valid), 1);
    @(negedge clk); #1; chk("t6_a2", 32'(acc_valid), 1);
    @(negedge clk); reset = 1'b1; #1;
    @(negedge clk); reset = 1'b0; #1;
    all_zero("t6_post");
    $display("T6 reset mid-job grant_valid=%0d done=%0d", grant_valid, done);
    @(negedge clk); req_valid = 4'b0101; req_len[15:0] = 16'd2; req_len[47:32] = 16'd2; #1;
    chk("t6_reack", 32'(req_ack), 32'b0001);
    @(negedge clk); req_valid = '0; #1;
    chk("t6_clear2", 32'(acc_clear), 1);
    @(negedge clk); #1; chk("t6_b1", 32'(acc_valid), 1);
    @(negedge clk); #1; chk("t6_b2", 32'(acc_valid), 1);
    @(negedge clk); #1; chk("t6_flush_rdy", 32'(vec_ready), 0);
    @(negedge clk); #1;
    chk("t6_done", 32'(done), 1);
    chk("t6_didx", 32'(done_idx), 0);
    chk("t6_dcnt", 32'(done_count), 2);
    $display("T6 job idx=0 len=2 done_count=%0d", done_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
